// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: memory-side responder for the L1 D-cache D_* port.
// Runs 4-beat line reads and single-word writes against a byte-enabled SRAM.
// Ports: clk, rst (sync, active high);
//   cache side: D_req, D_addr, D_write, D_in, D_type -> D_out, D_wait;
//   SRAM side: mem_cs, mem_oe, mem_web, mem_a, mem_di <- mem_do;
//   align_err: sticky misalignment flag.
// Optional: define DRESP_ALIGN_CHECK_EN to build the alignment checker;
// otherwise align_err is tied low.

`ifndef CACHE_TYPE_BITS
`define CACHE_TYPE_BITS 3
`endif
`ifndef CACHE_BYTE
`define CACHE_BYTE    3'b000
`endif
`ifndef CACHE_HWORD
`define CACHE_HWORD   3'b001
`endif
`ifndef CACHE_WORD
`define CACHE_WORD    3'b010
`endif
`ifndef CACHE_BYTE_U
`define CACHE_BYTE_U  3'b100
`endif
`ifndef CACHE_HWORD_U
`define CACHE_HWORD_U 3'b101
`endif

module dcache_mem_responder #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 2,
    parameter int BEATS   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        D_req,
    input  logic [31:0]                 D_addr,
    input  logic                        D_write,
    input  logic [31:0]                 D_in,
    input  logic [`CACHE_TYPE_BITS-1:0] D_type,
    output logic [31:0]                 D_out,
    output logic                        D_wait,
    output logic                        mem_cs,
    output logic                        mem_oe,
    output logic [3:0]                  mem_web,
    output logic [ADDR_W-1:0]           mem_a,
    output logic [31:0]                 mem_di,
    input  logic [31:0]                 mem_do,
    output logic                        align_err
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [3:0] LAT_LAST =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RD_ACC, S_RD_DONE, S_WR_ACC
    } state_t;

    state_t                      r_state;
    logic                        r_write;
    logic [ADDR_W-1:0]           r_wa;
    logic [1:0]                  r_off;
    logic [31:0]                 r_din;
    logic [`CACHE_TYPE_BITS-1:0] r_type;
    logic [BW-1:0]               r_beat;
    logic [3:0]                  r_lat;
    logic [31:0]                 r_dout;
    logic                        r_mem_cs;
    logic                        r_mem_oe;
    logic [3:0]                  r_mem_web;
    logic [ADDR_W-1:0]           r_mem_a;
    logic [31:0]                 r_mem_di;

    logic [ADDR_W-1:0] w_wa;
    logic [ADDR_W-1:0] w_line;
    logic [ADDR_W-1:0] w_rd_a;
    logic [3:0]        w_web_in;
    logic [3:0]        w_web_lat;
    logic [31:0]       w_di_in;
    logic [31:0]       w_di_lat;
    logic              w_wait;
    logic              w_unused_addr;

    // 0 = byte, 1 = halfword, 2 = word (unknown types fall to word)
    function automatic logic [1:0] size_of(
        input logic [`CACHE_TYPE_BITS-1:0] t);
        case (t)
            `CACHE_BYTE, `CACHE_BYTE_U:   size_of = 2'd0;
            `CACHE_HWORD, `CACHE_HWORD_U: size_of = 2'd1;
            default:                      size_of = 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] steer_web(
        input logic [`CACHE_TYPE_BITS-1:0] t, input logic [1:0] o);
        case (size_of(t))
            2'd0:    steer_web = ~(4'b0001 << o);
            2'd1:    steer_web = o[1] ? 4'b0011 : 4'b1100;
            default: steer_web = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] steer_di(
        input logic [`CACHE_TYPE_BITS-1:0] t, input logic [31:0] d);
        case (size_of(t))
            2'd0:    steer_di = {4{d[7:0]}};
            2'd1:    steer_di = {2{d[15:0]}};
            default: steer_di = d;
        endcase
    endfunction

    assign w_wa      = D_addr[ADDR_W+1:2];
    assign w_line    = w_wa & LINE_MASK;
    // Beat address wraps inside ADDR_W by plain truncation.
    assign w_rd_a    = r_wa + ADDR_W'(r_beat);
    // With LATENCY = 0 the access issues straight from IDLE, before the
    // request fields are latched, so steering also runs on the live inputs.
    assign w_web_in  = steer_web(D_type, D_addr[1:0]);
    assign w_di_in   = steer_di(D_type, D_in);
    assign w_web_lat = steer_web(r_type, r_off);
    assign w_di_lat  = steer_di(r_type, r_din);
    assign w_unused_addr = ^D_addr[31:ADDR_W+2];

    always_comb begin
        w_wait = 1'b1;
        if (rst) begin
            w_wait = 1'b0;
        end else begin
            case (r_state)
                S_IDLE:              w_wait = D_req;
                S_RD_DONE, S_WR_ACC: w_wait = 1'b0;
                default:             w_wait = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_wa      <= '0;
            r_off     <= 2'b00;
            r_din     <= 32'h0;
            r_type    <= `CACHE_WORD;
            r_beat    <= '0;
            r_lat     <= 4'd0;
            r_dout    <= 32'h0;
            r_mem_cs  <= 1'b0;
            r_mem_oe  <= 1'b0;
            r_mem_web <= 4'hf;
            r_mem_a   <= '0;
            r_mem_di  <= 32'h0;
        end else begin
            // SRAM strobes are single-cycle pulses
            r_mem_cs  <= 1'b0;
            r_mem_oe  <= 1'b0;
            r_mem_web <= 4'hf;
            case (r_state)
                S_IDLE: begin
                    if (D_req) begin
                        r_write <= D_write;
                        r_beat  <= '0;
                        r_lat   <= 4'd0;
                        if (D_write) begin
                            r_wa   <= w_wa;
                            r_off  <= D_addr[1:0];
                            r_din  <= D_in;
                            r_type <= D_type;
                        end else begin
                            r_wa <= w_line;
                        end
                        if (LATENCY == 0) begin
                            r_mem_cs <= 1'b1;
                            if (D_write) begin
                                r_state   <= S_WR_ACC;
                                r_mem_a   <= w_wa;
                                r_mem_web <= w_web_in;
                                r_mem_di  <= w_di_in;
                            end else begin
                                r_state  <= S_RD_ACC;
                                r_mem_oe <= 1'b1;
                                r_mem_a  <= w_line;
                            end
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_mem_cs <= 1'b1;
                        if (r_write) begin
                            r_state   <= S_WR_ACC;
                            r_mem_a   <= r_wa;
                            r_mem_web <= w_web_lat;
                            r_mem_di  <= w_di_lat;
                        end else begin
                            r_state  <= S_RD_ACC;
                            r_mem_oe <= 1'b1;
                            r_mem_a  <= w_rd_a;
                        end
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                S_RD_ACC: r_state <= S_RD_DONE;
                S_RD_DONE: begin
                    r_dout <= mem_do;
                    if (r_beat == BEAT_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_beat <= r_beat + BW'(1);
                        r_lat  <= 4'd0;
                        if (LATENCY == 0) begin
                            r_state  <= S_RD_ACC;
                            r_mem_cs <= 1'b1;
                            r_mem_oe <= 1'b1;
                            r_mem_a  <= w_rd_a + ADDR_W'(1);
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WR_ACC: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // SRAM data arrives during RD_DONE; pass it through then, hold afterwards.
    assign D_out   = (r_state == S_RD_DONE) ? mem_do : r_dout;
    assign D_wait  = w_wait;
    assign mem_cs  = r_mem_cs;
    assign mem_oe  = r_mem_oe;
    assign mem_web = r_mem_web;
    assign mem_a   = r_mem_a;
    assign mem_di  = r_mem_di;

`ifdef DRESP_ALIGN_CHECK_EN
    logic r_align;
    logic w_misal;

    always_comb begin
        w_misal = 1'b0;
        if (!D_write) begin
            w_misal = (D_addr[3:0] != 4'h0);
        end else begin
            case (size_of(D_type))
                2'd1:    w_misal = D_addr[0];
                2'd2:    w_misal = (D_addr[1:0] != 2'b00);
                default: w_misal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_align <= 1'b0;
        end else if (r_state == S_IDLE && D_req && w_misal) begin
            r_align <= 1'b1;
        end
    end

    assign align_err = r_align;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb_dcache_mem_responder: directed bench with a cycle-schedule model
// and a simple byte-enabled SRAM behind the responder.

module tb_dcache_mem_responder;

    localparam int L  = 2;
    localparam int AW = 14;
    localparam int NC = 1024;
    localparam logic [2:0] T_BYTE    = 3'b000;
    localparam logic [2:0] T_HWORD   = 3'b001;
    localparam logic [2:0] T_WORD    = 3'b010;
    localparam logic [2:0] T_BYTE_U  = 3'b100;
    localparam logic [2:0] T_HWORD_U = 3'b101;
`ifdef DRESP_ALIGN_CHECK_EN
    localparam logic AL_ON = 1'b1;
`else
    localparam logic AL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          D_req = 1'b0;
    logic [31:0]   D_addr = 32'h0;
    logic          D_write = 1'b0;
    logic [31:0]   D_in = 32'h0;
    logic [2:0]    D_type = T_WORD;
    logic [31:0]   D_out;
    logic          D_wait;
    logic          mem_cs;
    logic          mem_oe;
    logic [3:0]    mem_web;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_di;
    logic [31:0]   mem_do = 32'h0;
    logic          align_err;

    dcache_mem_responder #(.ADDR_W(AW), .LATENCY(L), .BEATS(4)) dut (
        .clk(clk), .rst(rst), .D_req(D_req), .D_addr(D_addr),
        .D_write(D_write), .D_in(D_in), .D_type(D_type),
        .D_out(D_out), .D_wait(D_wait), .mem_cs(mem_cs),
        .mem_oe(mem_oe), .mem_web(mem_web), .mem_a(mem_a),
        .mem_di(mem_di), .mem_do(mem_do), .align_err(align_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] sram    [16384];
    logic [31:0] ref_mem [16384];

    always @(posedge clk) begin
        if (mem_cs && mem_oe) mem_do <= sram[mem_a];
        if (mem_cs && !mem_oe) begin
            for (int i = 0; i < 4; i++)
                if (!mem_web[i]) sram[mem_a][8*i +: 8] <= mem_di[8*i +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- model: per-cycle expected events ----------------
    bit          done_at [NC];
    bit          rdd_at  [NC];
    bit          acc_at  [NC];
    bit          acc_rd  [NC];
    logic [AW-1:0] acc_a [NC];
    logic [3:0]  acc_web [NC];
    logic [31:0] acc_di  [NC];
    logic [31:0] dout_at [NC];
    int          busy_end = -1;
    logic [31:0] held = 32'h0;
    logic        al_exp = 1'b0;

    function automatic int nbytes(input logic [2:0] t);
        if (t == T_BYTE || t == T_BYTE_U) return 1;
        if (t == T_HWORD || t == T_HWORD_U) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] t,
                                         input logic [1:0] off);
        int n = nbytes(t);
        int s = (int'(off) / n) * n;
        logic [3:0] w = 4'hf;
        for (int i = 0; i < 4; i++)
            if (i >= s && i < s + n) w[i] = 1'b0;
        return w;
    endfunction

    function automatic logic [31:0] rep(input logic [2:0] t,
                                        input logic [31:0] d);
        int n = nbytes(t);
        if (n == 1) return {4{d[7:0]}};
        if (n == 2) return {2{d[15:0]}};
        return d;
    endfunction

    always @(negedge clk) begin
        int c;
        int d;
        logic ew;
        logic [31:0] ed;
        logic [AW-1:0] base;
        c = cyc;
        if (c + 120 < NC) begin
            if (rst)             ew = 1'b0;
            else if (done_at[c]) ew = 1'b0;
            else if (c <= busy_end) ew = 1'b1;
            else                 ew = D_req;
            chk("D_wait", {31'b0, D_wait}, {31'b0, ew});
            chk("mem_cs", {31'b0, mem_cs}, {31'b0, acc_at[c]});
            if (acc_at[c]) begin
                chk("mem_oe", {31'b0, mem_oe}, {31'b0, acc_rd[c]});
                chk("mem_a", 32'(mem_a), 32'(acc_a[c]));
                if (!acc_rd[c]) begin
                    chk("mem_web", {28'b0, mem_web}, {28'b0, acc_web[c]});
                    chk("mem_di", mem_di, acc_di[c]);
                    for (int i = 0; i < 4; i++)
                        if (!acc_web[c][i])
                            ref_mem[acc_a[c]][8*i +: 8] = acc_di[c][8*i +: 8];
                end
            end else begin
                chk("mem_web_idle", {28'b0, mem_web}, 32'hf);
            end
            ed = rdd_at[c] ? dout_at[c] : held;
            chk("D_out", D_out, ed);
            held = ed;
            chk("align_err", {31'b0, align_err}, {31'b0, al_exp});

            if (rst) begin
                for (int i = c + 1; i < c + 100; i++) begin
                    done_at[i] = 0; rdd_at[i] = 0;
                    acc_at[i] = 0; acc_rd[i] = 0;
                end
                busy_end = c;
                held = 32'h0;
                al_exp = 1'b0;
            end else if (c > busy_end && D_req) begin
                if (AL_ON) begin
                    if (!D_write) begin
                        if (D_addr[3:0] != 4'h0) al_exp = 1'b1;
                    end else if (nbytes(D_type) == 2) begin
                        if (D_addr[0]) al_exp = 1'b1;
                    end else if (nbytes(D_type) == 4) begin
                        if (D_addr[1:0] != 2'b00) al_exp = 1'b1;
                    end
                end
                if (!D_write) begin
                    base = {D_addr[AW+1:4], 2'b00};
                    for (int k = 0; k < 4; k++) begin
                        d = c + (k + 1) * (L + 2);
                        acc_at[d-1] = 1; acc_rd[d-1] = 1;
                        acc_a[d-1]  = base + AW'(k);
                        done_at[d]  = 1; rdd_at[d] = 1;
                        dout_at[d]  = ref_mem[base + AW'(k)];
                    end
                    busy_end = c + 4 * (L + 2);
                end else begin
                    d = c + L + 1;
                    acc_at[d]  = 1; acc_rd[d] = 0;
                    acc_a[d]   = D_addr[AW+1:2];
                    acc_web[d] = lanes(D_type, D_addr[1:0]);
                    acc_di[d]  = rep(D_type, D_in);
                    done_at[d] = 1;
                    busy_end   = d;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv_at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_cyc(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
        if (cyc != n) begin
            total++;
            bad++;
            $display("FAIL sched cyc=%0d want=%0d", cyc, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 16384; i++) begin
            sram[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        for (int i = 0; i < 4; i++) begin
            sram[32'h40 + i]    = 32'hA0 + i;
            ref_mem[32'h40 + i] = 32'hA0 + i;
        end

        drv_at(3);
        rst = 1'b0;
        at_cyc(4);
        chk("rst_wait", {31'b0, D_wait}, 32'h0);
        chk("rst_cs", {31'b0, mem_cs}, 32'h0);
        chk("rst_web", {28'b0, mem_web}, 32'hf);
        chk("rst_dout", D_out, 32'h0);

        // line read, misaligned address masked to line base
        drv_at(6);
        D_req = 1; D_write = 0; D_addr = 32'h104;
        t = cyc;
        at_cyc(t + 3);  chk("rd_w3", {31'b0, D_wait}, 32'h1);
        at_cyc(t + 4);  chk("rd_b0", D_out, 32'hA0);
        chk("rd_w4", {31'b0, D_wait}, 32'h0);
        at_cyc(t + 8);  chk("rd_b1", D_out, 32'hA1);
        at_cyc(t + 12); chk("rd_b2", D_out, 32'hA2);
        drv_at(t + 13); D_req = 0;
        at_cyc(t + 16); chk("rd_b3", D_out, 32'hA3);
        chk("rd_w16", {31'b0, D_wait}, 32'h0);
        at_cyc(t + 17); chk("rd_idle_cs", {31'b0, mem_cs}, 32'h0);

        // byte write
        drv_at(t + 20);
        D_req = 1; D_write = 1; D_addr = 32'h102;
        D_in = 32'h000000EE; D_type = T_BYTE;
        t = cyc;
        at_cyc(t + 2);  chk("bw_w2", {31'b0, D_wait}, 32'h1);
        drv_at(t + 3);  D_req = 0;
        at_cyc(t + 3);
        chk("bw_a", 32'(mem_a), 32'h40);
        chk("bw_web", {28'b0, mem_web}, 32'hb);
        chk("bw_di", mem_di, 32'hEEEEEEEE);
        chk("bw_w3", {31'b0, D_wait}, 32'h0);

        // halfword write, next request held back-to-back
        drv_at(t + 6);
        D_req = 1; D_write = 1; D_addr = 32'h206;
        D_in = 32'h00001234; D_type = T_HWORD;
        t = cyc;
        drv_at(t + 3);
        D_addr = 32'h303; D_in = 32'h0000005A; D_type = T_BYTE_U;
        at_cyc(t + 3);
        chk("hw_web", {28'b0, mem_web}, 32'h3);
        chk("hw_di", mem_di, 32'h12341234);
        chk("hw_a", 32'(mem_a), 32'h81);
        at_cyc(t + 4);  chk("b2b_w4", {31'b0, D_wait}, 32'h1);
        drv_at(t + 7);  D_req = 0;
        at_cyc(t + 7);
        chk("b2b_web", {28'b0, mem_web}, 32'h7);
        chk("b2b_di", mem_di, 32'h5A5A5A5A);

        // reset in the middle of a read burst
        drv_at(t + 10);
        D_req = 1; D_write = 0; D_addr = 32'h100; D_type = T_WORD;
        t = cyc;
        drv_at(t + 1);  D_req = 0;
        at_cyc(t + 4);  chk("rr_b0", D_out, 32'h00EE00A0);
        drv_at(t + 6);  rst = 1;
        drv_at(t + 7);  rst = 0;
        at_cyc(t + 7);  chk("rr_cs", {31'b0, mem_cs}, 32'h0);
        at_cyc(t + 8);  chk("rr_dout", D_out, 32'h0);
        drv_at(t + 10);
        D_req = 1; D_addr = 32'h200;
        t = cyc;
        drv_at(t + 1);  D_req = 0;
        at_cyc(t + 3);  chk("nr_w3", {31'b0, D_wait}, 32'h1);
        at_cyc(t + 4);  chk("nr_w4", {31'b0, D_wait}, 32'h0);
        at_cyc(t + 8);  chk("nr_b1", D_out, 32'h12340000);

        // misaligned word write
        drv_at(t + 18);
        D_req = 1; D_write = 1; D_addr = 32'h101;
        D_in = 32'hCAFEF00D; D_type = T_WORD;
        t = cyc;
        at_cyc(t);      chk("al_pre", {31'b0, align_err}, 32'h0);
        at_cyc(t + 1);  chk("al_set", {31'b0, align_err}, {31'b0, AL_ON});
        drv_at(t + 3);  D_req = 0;
        at_cyc(t + 3);
        chk("al_a", 32'(mem_a), 32'h40);
        chk("al_web", {28'b0, mem_web}, 32'h0);
        chk("al_di", mem_di, 32'hCAFEF00D);
        at_cyc(t + 6);  chk("al_hold", {31'b0, align_err}, {31'b0, AL_ON});

        // read back the overwritten line
        drv_at(t + 8);
        D_req = 1; D_write = 0; D_addr = 32'h100;
        t = cyc;
        drv_at(t + 1);  D_req = 0;
        at_cyc(t + 4);  chk("rb_b0", D_out, 32'hCAFEF00D);
        at_cyc(t + 18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the L1 data cache's D_* request interface.
- Accepts single-word writes and 4-word line-fill reads from the cache and drives a word-wide, byte-write-enabled SRAM macro.
- Generates D_wait and D_out with the beat timing the cache miss/write FSMs expect.
- Sits between L1C_data and the data SRAM wrapper; it replaces the AXI path when the cache runs in local-memory configuration.

Parameters:
- ADDR_W, 14, SRAM word-address width. mem_a is D_addr[ADDR_W+1:2].
- LATENCY, 2, wait cycles inserted before each SRAM access. Range 0..15.
- BEATS, 4, words per line fill. Fixed by the cache line size; power of two.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- D_req  input  1  request from cache
- D_addr  input  32  byte address
- D_write  input  1  1 = write, 0 = line read
- D_in  input  32  write data, right-aligned (byte in [7:0], half in [15:0])
- D_type  input  `CACHE_TYPE_BITS  access size (`CACHE_BYTE/HWORD/WORD/BYTE_U/HWORD_U`)
- D_out  output  32  read beat data
- D_wait  output  1  busy; low for one cycle per completed beat
- mem_cs  output  1  SRAM chip select
- mem_oe  output  1  SRAM output enable
- mem_web  output  4  per-byte write enable, active low
- mem_a  output  ADDR_W  SRAM word address
- mem_di  output  32  SRAM write data
- mem_do  input  32  SRAM read data, valid the cycle after a read access
- align_err  output  1  misalignment flag (see Optional Feature)

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; beat counter 0; latency counter 0; D_out 0; mem_cs 0; mem_oe 0; mem_web 4'hf; mem_a 0; mem_di 0; align_err 0.
- D_wait while rst is asserted: 0.
- States: IDLE, WAIT, RD_ACC, RD_DONE, WR_ACC.
- D_wait is combinational:
  - IDLE: D_wait = D_req.
  - RD_DONE and WR_ACC: D_wait = 0.
  - All other states: D_wait = 1.
- IDLE, on D_req:
  - Latch address and write flag.
  - On a write, also latch data and type.
  - Read address is forced to line base, D_addr[31:4],4'b0; beat counter is set to 0.
  - Next state is WAIT. If LATENCY = 0, go directly to RD_ACC or WR_ACC.
- WAIT: counts LATENCY cycles, then goes to RD_ACC or WR_ACC. D_req, D_addr and D_in are ignored from acceptance until the transaction returns to IDLE.
- RD_ACC:
  - mem_cs = 1, mem_oe = 1, mem_a = line base word + beat counter.
  - Next state RD_DONE.
- RD_DONE:
  - D_out = mem_do, registered and held until the next RD_DONE. D_wait = 0.
  - If beat counter = BEATS-1, go to IDLE. Otherwise increment the counter and go to WAIT (or RD_ACC when LATENCY = 0).
- Read timing:
  - Accept at cycle T.
  - Beat k completes (D_wait low) at T + (k+1)(LATENCY+2).
  - With LATENCY = 2: T+4, T+8, T+12, T+16.
- Read requests always complete BEATS beats, even if the cache drops D_req early. The cache drops D_req while waiting for the last beat.
- WR_ACC:
  - mem_cs = 1, mem_oe = 0. D_wait = 0 this cycle. Next state IDLE.
  - Write completes at T + LATENCY + 1.
- Write lane steering, o = latched addr[1:0]:
  - Byte: mem_di = {4{D_in[7:0]}}; mem_web lane o = 0, other lanes 1.
  - Halfword: mem_di = {2{D_in[15:0]}}; lanes {o[1],0} and {o[1],1} = 0.
  - Word: mem_di = D_in; mem_web = 4'h0.
  - _U types are handled identically to their signed forms.
  - Unknown type is treated as word.
- A request held on D_req during the RD_DONE or WR_ACC cycle is not accepted there. It is accepted in the following IDLE cycle, where D_wait returns to 1.
- Reads always return full words; lane extraction belongs to the core.
- Reset mid-transaction:
  - The next cycle is IDLE with counters cleared.
  - An in-flight beat is discarded.
  - A write that has not reached WR_ACC is never issued.
- The last beat's row wraps within ADDR_W; no error is raised.

Optional Feature:
- Macro: DRESP_ALIGN_CHECK_EN.
- When defined, at acceptance align_err is set sticky (cleared only by rst) on any of:
  - read with D_addr[3:0] != 0;
  - halfword write with D_addr[0] = 1;
  - word write with D_addr[1:0] != 0.
- The access still proceeds with low bits masked as above.
- When not defined, align_err is tied 0 and no check logic is built.

Test Plan:
- Reset, then D_req=0 idle -> D_wait=0, mem_cs=0, mem_web=4'hf, D_out=0.
- LATENCY=2; SRAM words 0x40..0x43 preloaded with 0xA0..0xA3; read D_addr=0x104 -> masked to line base 0x100, D_wait low at T+4/8/12/16 with D_out 0xA0,0xA1,0xA2,0xA3; IDLE after the last beat, even with D_req dropped after the third beat.
- Byte write D_addr=0x102, D_in=0x000000EE -> WR_ACC at T+3: mem_a=0x40, mem_web=4'b1011, mem_di=0xEEEEEEEE; D_wait low exactly that cycle.
- Halfword write D_addr=0x206, D_in=0x1234, back-to-back with the next request held high -> mem_web=4'b0011; second request accepted the cycle after WR_ACC.
- rst asserted at T+6 of a read burst -> next cycle IDLE; the remaining beats never appear; a new read completes its first beat at full latency.
- With DRESP_ALIGN_CHECK_EN: word write D_addr=0x101 -> align_err=1 and stays set; write still lands at word 0x40 with mem_web=4'h0. Without the macro -> align_err stays 0.
